// File: rtl/start_window_ctrl.sv
// Start-deadline watchdog: arm opens a WINDOW-edge sampling window on start and
// reports pass/fail/abort, first-hit latency and a saturating hit count.
module start_window_ctrl #(
  parameter int unsigned WINDOW     = 20,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned HIT_W      = 8,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic             start,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] latency,
  output logic [HIT_W-1:0] hit_count
);

  typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW);
  localparam logic [HIT_W-1:0] HIT_MAX  = '1;
  localparam logic [1:0] ST_NONE  = 2'b00;
  localparam logic [1:0] ST_PASS  = 2'b01;
  localparam logic [1:0] ST_FAIL  = 2'b10;
  localparam logic [1:0] ST_ABORT = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] edge_idx;
  logic [HIT_W-1:0] hits_inc;
  logic             early_exit_en;

  // Edge index of the current sample and the saturated hit increment.
  assign edge_idx      = cnt + CNT_W'(1);
  assign hits_inc      = (hit_count == HIT_MAX) ? hit_count : hit_count + HIT_W'(1);
  assign early_exit_en = (EARLY_EXIT != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      status    <= ST_NONE;
      latency   <= '0;
      hit_count <= '0;
    end else begin
      pass <= 1'b0;
      fail <= 1'b0;
      case (state)
        ARMED: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            status <= ST_ABORT;
          end else if (arm) begin
            // Restart: the old window is dropped without a verdict.
            cnt       <= '0;
            latency   <= '0;
            hit_count <= '0;
            status    <= ST_NONE;
          end else begin
            cnt <= edge_idx;
            if (start) begin
              hit_count <= hits_inc;
              if (hit_count == '0) latency <= edge_idx;
            end
            if (start && early_exit_en) begin
              state  <= DONE;
              busy   <= 1'b0;
              pass   <= 1'b1;
              status <= ST_PASS;
            end else if (edge_idx == WIN_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              if (start || hit_count != '0) begin
                pass   <= 1'b1;
                status <= ST_PASS;
              end else begin
                fail    <= 1'b1;
                status  <= ST_FAIL;
                latency <= '0;
              end
            end
          end
        end
        default: begin
          // IDLE and DONE: abort (alone or with arm) leaves everything as is.
          if (arm && !abort) begin
            state     <= ARMED;
            busy      <= 1'b1;
            cnt       <= '0;
            latency   <= '0;
            hit_count <= '0;
            status    <= ST_NONE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_start_window_ctrl.sv
// Self-checking bench: three configurations of start_window_ctrl driven with directed
// and random stimulus, compared every cycle against a behavioural model.
module tb_start_window_ctrl;

  logic clk = 1'b0;
  logic rst_n, arm, abort, start;

  logic       b0, p0, f0, b1, p1, f1, b2, p2, f2;
  logic [1:0] s0, s1, s2;
  logic [7:0] l0, h0, l1, h1;
  logic [2:0] l2;
  logic [1:0] h2;

  int n_chk = 0;
  int n_err = 0;

  // Model configuration per instance: window length, hit ceiling, early exit.
  int p_win [3] = '{20, 20, 7};
  int p_hmax[3] = '{255, 255, 3};
  int p_ee  [3] = '{1, 0, 0};

  bit m_open[3];
  int m_k[3], m_hits[3], m_lat[3], m_st[3];
  bit m_p[3], m_f[3];

  start_window_ctrl #(.WINDOW(20), .CNT_W(8), .HIT_W(8), .EARLY_EXIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .start(start),
    .busy(b0), .pass(p0), .fail(f0), .status(s0), .latency(l0), .hit_count(h0));
  start_window_ctrl #(.WINDOW(20), .CNT_W(8), .HIT_W(8), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .start(start),
    .busy(b1), .pass(p1), .fail(f1), .status(s1), .latency(l1), .hit_count(h1));
  start_window_ctrl #(.WINDOW(7), .CNT_W(3), .HIT_W(2), .EARLY_EXIT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .start(start),
    .busy(b2), .pass(p2), .fail(f2), .status(s2), .latency(l2), .hit_count(h2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Window semantics expressed as: open window, edge index k, hits so far, verdict.
  task automatic model_step(input int i);
    m_p[i] = 1'b0;
    m_f[i] = 1'b0;
    if (m_open[i]) begin
      if (abort) begin
        m_open[i] = 1'b0;
        m_st[i]   = 3;
      end else if (arm) begin
        m_k[i] = 0; m_hits[i] = 0; m_lat[i] = 0; m_st[i] = 0;
      end else begin
        m_k[i]++;
        if (start) begin
          if (m_hits[i] == 0) m_lat[i] = m_k[i];
          if (m_hits[i] < p_hmax[i]) m_hits[i]++;
        end
        if (p_ee[i] != 0 && start) begin
          m_open[i] = 1'b0; m_p[i] = 1'b1; m_st[i] = 1;
        end else if (m_k[i] == p_win[i]) begin
          m_open[i] = 1'b0;
          if (m_hits[i] > 0) begin
            m_p[i] = 1'b1; m_st[i] = 1;
          end else begin
            m_f[i] = 1'b1; m_st[i] = 2; m_lat[i] = 0;
          end
        end
      end
    end else if (arm && !abort) begin
      m_open[i] = 1'b1;
      m_k[i] = 0; m_hits[i] = 0; m_lat[i] = 0; m_st[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_open[i] = 1'b0; m_k[i] = 0; m_hits[i] = 0; m_lat[i] = 0;
        m_st[i] = 0; m_p[i] = 1'b0; m_f[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  task automatic cmp(input int i, input logic b, input logic p, input logic f,
                     input logic [1:0] s, input logic [31:0] l, input logic [31:0] h);
    chk($sformatf("u%0d.busy", i), 32'(b), 32'(m_open[i]));
    chk($sformatf("u%0d.pass", i), 32'(p), 32'(m_p[i]));
    chk($sformatf("u%0d.fail", i), 32'(f), 32'(m_f[i]));
    chk($sformatf("u%0d.status", i), 32'(s), 32'(m_st[i]));
    chk($sformatf("u%0d.latency", i), l, 32'(m_lat[i]));
    chk($sformatf("u%0d.hit_count", i), h, 32'(m_hits[i]));
    chk($sformatf("u%0d.pass_and_fail", i), 32'(p & f), 32'd0);
  endtask

  always @(negedge clk) begin
    cmp(0, b0, p0, f0, s0, 32'(l0), 32'(h0));
    cmp(1, b1, p1, f1, s1, 32'(l1), 32'(h1));
    cmp(2, b2, p2, f2, s2, 32'(l2), 32'(h2));
  end

  // Drive one cycle's inputs, then return 2 time units after the sampling edge.
  task automatic cyc(input logic a, input logic ab, input logic st);
    arm = a; abort = ab; start = st;
    @(posedge clk);
    #2;
  endtask

  int  nb;
  logic seen;

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset.busy", 32'(b0), 0);
    chk("reset.status", 32'(s0), 0);
    chk("reset.latency", 32'(l0), 0);
    chk("reset.hit_count", 32'(h0), 0);
    rst_n = 1'b1;

    // Early exit on a hit at edge 9.
    cyc(1, 0, 0);
    repeat (8) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("t1.pass", 32'(p0), 1);
    chk("t1.latency", 32'(l0), 9);
    chk("t1.hit_count", 32'(h0), 1);
    chk("t1.status", 32'(s0), 1);
    cyc(0, 0, 0);
    chk("t1.pass_one_cycle", 32'(p0), 0);

    // No hit in 20 edges: fail, busy exactly 20 cycles.
    nb = 0;
    cyc(1, 0, 0); nb += int'(b0);
    for (int k = 1; k <= 20; k++) begin
      cyc(0, 0, 0); nb += int'(b0);
    end
    chk("t2.fail", 32'(f0), 1);
    chk("t2.status", 32'(s0), 2);
    chk("t2.latency", 32'(l0), 0);
    chk("t2.busy_cycles", 32'(nb), 20);

    // Full window with hits on edges 3, 4, 15.
    cyc(1, 0, 0);
    for (int k = 1; k <= 20; k++) cyc(0, 0, (k == 3 || k == 4 || k == 15));
    chk("t3.pass", 32'(p1), 1);
    chk("t3.latency", 32'(l1), 3);
    chk("t3.hit_count", 32'(h1), 3);

    // Hit on the last edge passes; a hit one edge late does not count.
    cyc(1, 0, 0);
    for (int k = 1; k <= 20; k++) cyc(0, 0, (k == 20));
    chk("t4.last_edge_pass", 32'(p0), 1);
    chk("t4.last_edge_latency", 32'(l0), 20);
    cyc(1, 0, 0);
    for (int k = 1; k <= 20; k++) cyc(0, 0, 0);
    chk("t4.late_fail", 32'(f0), 1);
    cyc(0, 0, 1);
    chk("t4.late_status", 32'(s0), 2);
    chk("t4.late_hits", 32'(h0), 0);

    // Abort, arm+abort, and re-arm restarting the count.
    cyc(1, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("t5.abort_busy", 32'(b0), 0);
    chk("t5.abort_status", 32'(s0), 3);
    chk("t5.abort_pulses", 32'(p0 | f0), 0);
    cyc(1, 0, 0);
    for (int k = 1; k <= 6; k++) cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("t5.arm_abort_busy", 32'(b0), 0);
    chk("t5.arm_abort_status", 32'(s0), 3);
    cyc(1, 0, 0);
    for (int k = 1; k <= 9; k++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("t5.rearm_busy", 32'(b0), 1);
    chk("t5.rearm_status", 32'(s0), 0);
    cyc(0, 0, 1);
    chk("t5.rearm_latency", 32'(l0), 1);
    chk("t5.rearm_pass", 32'(p0), 1);
    cyc(0, 1, 0);
    chk("t5.idle_abort_ignored", 32'(s0), 1);

    // Start during the arm cycle is ignored; reset mid-window clears everything.
    cyc(1, 0, 1);
    cyc(0, 0, 0);
    chk("t6.arm_cycle_start", 32'(h0), 0);
    for (int k = 2; k <= 11; k++) cyc(0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6.async_busy", 32'(b0), 0);
    chk("t6.async_status", 32'(s0), 0);
    repeat (2) cyc(0, 0, 1);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      cyc(0, 0, 1);
      seen = seen | p0 | f0;
    end
    chk("t6.no_pulse", 32'(seen), 0);
    chk("t6.busy", 32'(b0), 0);
    chk("t6.hit_count", 32'(h0), 0);
    chk("t6.latency", 32'(l0), 0);

    // Saturation of a 2-bit hit counter over a 7-edge window.
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 1);
    chk("t7.hit_sat", 32'(h2), 3);
    chk("t7.latency", 32'(l2), 1);
    chk("t7.pass", 32'(p2), 1);

    // Random traffic checked by the per-cycle compare.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cyc(0, 0, 0);
        rst_n = 1'b1;
      end
      cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) == 0));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
